// File: rtl/bin_para_bcd_seq.sv
// bin_para_bcd_seq: sequential binary-to-BCD converter (shift-and-add-3),
// one input bit per clock, with start/busy/done handshake.
// Ports:
//   clk, rst_n     clock, async active-low reset
//   inicio, bin    start request (idle only) and binary value to convert
//   ocupado        conversion in progress
//   pronto         one-cycle pulse, results below are fresh
//   bcd            DIGITOS packed BCD digits, digit 0 = units
//   estouro        captured value did not fit in DIGITOS digits
//   apaga_zero     leading-zero blanking mask, bit 0 always 0
module bin_para_bcd_seq #(
  parameter int LARGURA_BIN = 10,
  parameter int DIGITOS     = 3
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   inicio,
  input  logic [LARGURA_BIN-1:0] bin,
  output logic                   ocupado,
  output logic                   pronto,
  output logic [4*DIGITOS-1:0]   bcd,
  output logic                   estouro,
  output logic [DIGITOS-1:0]     apaga_zero
);

  localparam int CW = $clog2(LARGURA_BIN + 1);
  localparam int SW = 4 * DIGITOS;
  localparam logic [DIGITOS-1:0] APAGA_RST =
    {DIGITOS{1'b1}} << 1;

  typedef enum logic {
    OCIOSO,
    CONVERTE
  } estado_t;

  estado_t                r_estado;
  logic [LARGURA_BIN-1:0] r_bin;
  logic [SW-1:0]          r_scr;
  logic [CW-1:0]          r_cnt;
  logic                   r_ovf;
  logic                   r_ocupado;
  logic                   r_pronto;
  logic [SW-1:0]          r_bcd;
  logic                   r_estouro;
  logic [DIGITOS-1:0]     r_apaga;

  logic [SW-1:0]          w_adj;
  logic [SW-1:0]          w_scr_nxt;
  logic [LARGURA_BIN-1:0] w_bin_nxt;
  logic                   w_ovf_nxt;
  logic [DIGITOS-1:0]     w_apaga;
  logic                   w_acima;

  // One double-dabble step on the scratch register.
  always_comb begin
    w_adj = r_scr;
    for (int i = 0; i < DIGITOS; i++) begin
      if (r_scr[4*i +: 4] >= 4'd5)
        w_adj[4*i +: 4] = r_scr[4*i +: 4] + 4'd3;
    end
    w_scr_nxt = {w_adj[SW-2:0], r_bin[LARGURA_BIN-1]};
    w_bin_nxt = r_bin << 1;
    // A 1 leaving the top digit means the value has
    // reached 10^DIGITOS; lower digits stay exact.
    w_ovf_nxt = r_ovf | w_adj[SW-1];
  end

  // Bit i set when digit i and every digit above it are zero.
  always_comb begin
    w_acima = 1'b1;
    w_apaga = '0;
    for (int i = DIGITOS - 1; i >= 0; i--) begin
      w_acima    = w_acima & (w_scr_nxt[4*i +: 4] == 4'd0);
      w_apaga[i] = w_acima;
    end
    w_apaga[0] = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_estado  <= OCIOSO;
      r_bin     <= '0;
      r_scr     <= '0;
      r_cnt     <= '0;
      r_ovf     <= 1'b0;
      r_ocupado <= 1'b0;
      r_pronto  <= 1'b0;
      r_bcd     <= '0;
      r_estouro <= 1'b0;
      r_apaga   <= APAGA_RST;
    end else begin
      r_pronto <= 1'b0;
      unique case (r_estado)
        OCIOSO: begin
          if (inicio) begin
            r_bin     <= bin;
            r_scr     <= '0;
            r_ovf     <= 1'b0;
            r_cnt     <= CW'(LARGURA_BIN);
            r_ocupado <= 1'b1;
            r_estado  <= CONVERTE;
          end
        end
        CONVERTE: begin
          r_bin <= w_bin_nxt;
          r_scr <= w_scr_nxt;
          r_ovf <= w_ovf_nxt;
          r_cnt <= r_cnt - CW'(1);
          if (r_cnt == CW'(1)) begin
            r_bcd     <= w_scr_nxt;
            r_estouro <= w_ovf_nxt;
            r_apaga   <= w_apaga;
            r_pronto  <= 1'b1;
            r_ocupado <= 1'b0;
            r_estado  <= OCIOSO;
          end
        end
        default: r_estado <= OCIOSO;
      endcase
    end
  end

  assign ocupado    = r_ocupado;
  assign pronto     = r_pronto;
  assign bcd        = r_bcd;
  assign estouro    = r_estouro;
  assign apaga_zero = r_apaga;

endmodule

// File: tb/tb_bin_para_bcd_seq.sv
// tb_bin_para_bcd_seq: directed checks of bin_para_bcd_seq,
// default 10/3 instance plus a 16/5 instance.
module tb_bin_para_bcd_seq;

  logic clk;
  logic rst_n;

  logic        inicio_a;
  logic [9:0]  bin_a;
  logic        ocup_a;
  logic        pron_a;
  logic [11:0] bcd_a;
  logic        est_a;
  logic [2:0]  apz_a;

  logic        inicio_b;
  logic [15:0] bin_b;
  logic        ocup_b;
  logic        pron_b;
  logic [19:0] bcd_b;
  logic        est_b;
  logic [4:0]  apz_b;

  int checks = 0;
  int errors = 0;

  bin_para_bcd_seq u_a (
    .clk(clk), .rst_n(rst_n),
    .inicio(inicio_a), .bin(bin_a),
    .ocupado(ocup_a), .pronto(pron_a),
    .bcd(bcd_a), .estouro(est_a),
    .apaga_zero(apz_a)
  );

  bin_para_bcd_seq #(
    .LARGURA_BIN(16), .DIGITOS(5)
  ) u_b (
    .clk(clk), .rst_n(rst_n),
    .inicio(inicio_b), .bin(bin_b),
    .ocupado(ocup_b), .pronto(pron_b),
    .bcd(bcd_b), .estouro(est_b),
    .apaga_zero(apz_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference built by division, independent of the shift algorithm.
  function automatic logic [19:0] ref_bcd(input int v);
    logic [19:0] r;
    int x;
    r = '0;
    x = v;
    for (int d = 0; d < 5; d++) begin
      r[4*d +: 4] = 4'(x % 10);
      x = x / 10;
    end
    return r;
  endfunction

  function automatic logic [4:0] ref_apz(input logic [19:0] b);
    logic [4:0] m;
    logic z;
    z = 1'b1;
    m = '0;
    for (int d = 4; d >= 0; d--) begin
      z = z & (b[4*d +: 4] == 4'd0);
      m[d] = z;
    end
    m[0] = 1'b0;
    return m;
  endfunction

  task automatic run_a(input string tag,
                       input logic [9:0] v,
                       input logic [11:0] eb,
                       input logic eo,
                       input logic [2:0] ea);
    bin_a = v;
    inicio_a = 1'b1;
    tick();
    inicio_a = 1'b0;
    bin_a = ~v;
    chk({tag, " busy0"}, 32'(ocup_a), 32'd1);
    for (int k = 1; k < 10; k++) begin
      tick();
      chk({tag, " run"}, 32'({ocup_a, pron_a}), 32'b10);
    end
    tick();
    chk({tag, " done"}, 32'({ocup_a, pron_a}), 32'b01);
    chk({tag, " bcd"}, 32'(bcd_a), 32'(eb));
    chk({tag, " est"}, 32'(est_a), 32'(eo));
    chk({tag, " apz"}, 32'(apz_a), 32'(ea));
    tick();
    chk({tag, " pulse"}, 32'(pron_a), 32'd0);
    chk({tag, " hold"}, 32'(bcd_a), 32'(eb));
  endtask

  task automatic run_b(input string tag,
                       input logic [15:0] v,
                       input logic [19:0] eb);
    bin_b = v;
    inicio_b = 1'b1;
    tick();
    inicio_b = 1'b0;
    bin_b = ~v;
    for (int k = 1; k < 16; k++) begin
      tick();
      chk({tag, " run"}, 32'({ocup_b, pron_b}), 32'b10);
    end
    tick();
    chk({tag, " done"}, 32'({ocup_b, pron_b}), 32'b01);
    chk({tag, " bcd"}, 32'(bcd_b), 32'(eb));
    chk({tag, " est"}, 32'(est_b), 32'd0);
    chk({tag, " apz"}, 32'(apz_b), 32'(ref_apz(eb)));
    tick();
  endtask

  initial begin
    logic seen;
    logic [15:0] rv;
    inicio_a = 1'b0;
    bin_a = '0;
    inicio_b = 1'b0;
    bin_b = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #3;
    chk("rst ocup", 32'(ocup_a), 32'd0);
    chk("rst pronto", 32'(pron_a), 32'd0);
    chk("rst bcd", 32'(bcd_a), 32'd0);
    chk("rst est", 32'(est_a), 32'd0);
    chk("rst apz", 32'(apz_a), 32'b110);
    chk("rst apz b", 32'(apz_b), 32'b11110);
    tick();
    tick();
    rst_n = 1'b1;
    tick();

    run_a("999", 10'd999, 12'h999, 1'b0, 3'b000);
    run_a("0", 10'd0, 12'h000, 1'b0, 3'b110);
    run_a("7", 10'd7, 12'h007, 1'b0, 3'b110);
    run_a("42", 10'd42, 12'h042, 1'b0, 3'b100);
    run_a("1000", 10'd1000, 12'h000, 1'b1, 3'b110);
    run_a("1023", 10'd1023, 12'h023, 1'b1, 3'b100);
    run_a("999b", 10'd999, 12'h999, 1'b0, 3'b000);

    // Start ignored while busy, then back-to-back restart.
    bin_a = 10'd123;
    inicio_a = 1'b1;
    tick();
    inicio_a = 1'b0;
    tick();
    tick();
    tick();
    bin_a = 10'd456;
    inicio_a = 1'b1;
    tick();
    inicio_a = 1'b0;
    chk("ign busy", 32'(ocup_a), 32'd1);
    for (int k = 5; k < 10; k++) begin
      tick();
      chk("ign run", 32'({ocup_a, pron_a}), 32'b10);
    end
    tick();
    chk("ign done", 32'({ocup_a, pron_a}), 32'b01);
    chk("ign bcd", 32'(bcd_a), 32'h123);
    bin_a = 10'd456;
    inicio_a = 1'b1;
    tick();
    inicio_a = 1'b0;
    bin_a = '0;
    chk("b2b start", 32'({ocup_a, pron_a}), 32'b10);
    for (int k = 1; k < 10; k++) begin
      tick();
      chk("b2b run", 32'({ocup_a, pron_a}), 32'b10);
    end
    tick();
    chk("b2b done", 32'({ocup_a, pron_a}), 32'b01);
    chk("b2b bcd", 32'(bcd_a), 32'h456);
    chk("b2b apz", 32'(apz_a), 32'b000);
    tick();

    // Reset in the middle of a conversion.
    bin_a = 10'd500;
    inicio_a = 1'b1;
    tick();
    inicio_a = 1'b0;
    for (int k = 1; k < 5; k++) tick();
    #2 rst_n = 1'b0;
    #1;
    chk("mrst ocup", 32'(ocup_a), 32'd0);
    chk("mrst pronto", 32'(pron_a), 32'd0);
    chk("mrst bcd", 32'(bcd_a), 32'd0);
    chk("mrst est", 32'(est_a), 32'd0);
    chk("mrst apz", 32'(apz_a), 32'b110);
    tick();
    rst_n = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 14; k++) begin
      tick();
      seen = seen | pron_a | ocup_a;
    end
    chk("mrst quiet", 32'(seen), 32'd0);
    run_a("321", 10'd321, 12'h321, 1'b0, 3'b000);

    // Wide instance.
    run_b("65535", 16'hFFFF, 20'h65535);
    run_b("b0", 16'd0, 20'h00000);
    run_b("b100", 16'd100, 20'h00100);
    for (int n = 0; n < 1000; n++) begin
      rv = 16'($urandom_range(0, 65535));
      run_b("rnd", rv, ref_bcd(int'(rv)));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/bin_para_bcd_seq.md
Name: bin_para_bcd_seq

Overview:
Sequential, parametrised binary-to-BCD converter using the shift-and-add-3 (double-dabble) algorithm, one bit per clock. It generalises the stopwatch's combinational three-digit converter to any input width and digit count, and avoids wide dividers. It adds a start/busy/done handshake, an overflow flag and a leading-zero blanking mask for the 7-segment display driver.

Parameters:
LARGURA_BIN, 10, width of binary input in bits (>=1)
DIGITOS, 3, number of BCD digits produced (>=1)

Ports:
clk  in  1  system clock, all state updates on rising edge
rst_n  in  1  asynchronous active-low reset
inicio  in  1  start request, sampled only when idle
bin  in  LARGURA_BIN  binary value, captured on the accepted inicio edge
ocupado  out  1  high while a conversion is in progress
pronto  out  1  one-cycle pulse: new bcd/estouro/apaga_zero are valid
bcd  out  4*DIGITOS  result; digit i at bits [4i+3:4i], digit 0 = units
estouro  out  1  high if captured bin >= 10^DIGITOS
apaga_zero  out  DIGITOS  bit i high if digit i and all higher digits are zero; bit 0 always 0

Behaviour:
- Reset (rst_n low, asynchronous): state OCIOSO, bcd=0, estouro=0, apaga_zero = all ones except bit 0, pronto=0, ocupado=0, internal shift register and bit counter cleared. Reset mid-conversion aborts the conversion; no pronto is produced.
- States: OCIOSO, CONVERTE.
- OCIOSO: on an edge with inicio=1, capture bin, clear the BCD scratch register and the overflow accumulator, load counter=LARGURA_BIN, go to CONVERTE. inicio=0 leaves the state unchanged.
- CONVERTE: each edge performs one step. First, every scratch digit >=5 gets +3. Then the concatenation {scratch, binary} shifts left by 1. If the bit shifted out of the top digit is 1, the overflow accumulator is set. The counter decrements.
- On the edge that performs the last step (counter==1), all of the following happen together: bcd is loaded with the post-step scratch, estouro with the final accumulator, apaga_zero is computed from the new bcd, pronto=1 for the next cycle only, and the state returns to OCIOSO.
- Latency: inicio accepted at edge 0; results valid and pronto high after edge LARGURA_BIN. ocupado=1 from after edge 0 until edge LARGURA_BIN, and is 0 in the pronto cycle.
- inicio while ocupado=1: ignored, no queueing. inicio in the pronto cycle: accepted, so back-to-back conversions run with no idle gap.
- bin changes after capture have no effect on the conversion in progress.
- bcd, estouro and apaga_zero hold their values between completions.
- Overflow: bcd = bin mod 10^DIGITOS (lower digits are exact), estouro=1.
- Counter width = clog2(LARGURA_BIN+1). The scratch register is 4*DIGITOS bits.
- Fully synchronous except reset. No combinational path from inputs to outputs.

Test Plan:
- Defaults, bin=999, inicio pulse -> ocupado high for 10 cycles; then pronto for 1 cycle with bcd=0x999, estouro=0, apaga_zero=000.
- Defaults, bin=0 -> bcd=0x000, apaga_zero=110. Defaults, bin=7 -> bcd=0x007, apaga_zero=110. Defaults, bin=42 -> bcd=0x042, apaga_zero=100.
- Defaults, bin=1000 -> estouro=1, bcd=0x000. Defaults, bin=1023 -> estouro=1, bcd=0x023.
- Start bin=123; at cycle 4, pulse inicio with bin=456 -> ignored, result 0x123. Then assert inicio with bin=456 during the pronto cycle -> second pronto exactly 10 cycles later with bcd=0x456.
- Start bin=500; drop rst_n at cycle 5 -> all outputs go to their reset values immediately, and no pronto follows. After release, new inicio with bin=321 -> 0x321.
- LARGURA_BIN=16, DIGITOS=5, bin=65535 -> pronto after 16 cycles, bcd=0x65535, estouro=0. Random sweep of 1000 values is checked against a division reference model.
